cnet_dma_buffer: RTL and testbench



---
 rtl/cnet_dma_buffer_pkg.sv | 25 ++
 rtl/cnet_dma_sync_fifo.sv | 74 +++++++
 rtl/cnet_dma_buffer.sv | 107 ++++++++++
 tb/tb_cnet_dma_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cnet_dma_buffer_pkg.sv
// Shared constants, FSM encoding and header decode for the CPCI-to-DMA buffer.
// Sizes here are the defaults; the modules derive their widths from DEPTH.
package cnet_dma_buffer_pkg;

   localparam int DMA_DEPTH           = 512;
   localparam int DMA_ADDR_W          = 9;
   localparam int DMA_CNT_W           = 10;
   localparam int DMA_NEARLY_EMPTY_TH = 4;
   localparam int DMA_NEARLY_FULL_TH  = 4;
   localparam int DMA_REM_W           = 15;

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_BODY = 2'd1,
      ST_DONE = 2'd2
   } pkt_state_e;

   // Header length is in bytes; the body occupies ceil(len/4) 32-bit words.
   function automatic logic [DMA_REM_W-1:0] hdr_words(input logic [15:0] len);
      logic [16:0] t;
      t = {1'b0, len} + 17'd3;
      return t[16:2];
   endfunction

endpackage

// File: rtl/cnet_dma_sync_fifo.sv
// Single-clock 32-bit FIFO with registered read data and an exact word count.
// Writes while full and reads while empty are ignored.
module cnet_dma_sync_fifo
   import cnet_dma_buffer_pkg::*;
#(
   parameter int DEPTH  = DMA_DEPTH,
   parameter int ADDR_W = DMA_ADDR_W,
   parameter int CNT_W  = DMA_CNT_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_en_i,
   input  logic [31:0]       wr_data_i,
   input  logic              rd_en_i,
   output logic [31:0]       rd_data_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              wr_accept_o
);

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic              wr_accept, rd_accept;

   assign wr_accept = wr_en_i && (count_q < CNT_W'(DEPTH));
   assign rd_accept = rd_en_i && (count_q != '0);

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rd_data_d = rd_data_q;
      if (wr_accept) begin
         wr_ptr_d = (wr_ptr_q == ADDR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
         rd_ptr_d  = (rd_ptr_q == ADDR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
         rd_data_d = mem[rd_ptr_q];
      end
      if (wr_accept && !rd_accept) begin
         count_d = count_q + 1'b1;
      end else if (rd_accept && !wr_accept) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage is not reset; the pointers alone define which words are valid.
   always_ff @(posedge clk_i) begin
      if (wr_accept) begin
         mem[wr_ptr_q] <= wr_data_i;
      end
   end

   assign rd_data_o   = rd_data_q;
   assign count_o     = count_q;
   assign wr_accept_o = wr_accept;

endmodule

// File: rtl/cnet_dma_buffer.sv
// CPCI-to-DMA packet buffer: status pass-through, send-request latch, FIFO and
// a header/body tracker that reports when a whole packet is in the buffer.
module cnet_dma_buffer
   import cnet_dma_buffer_pkg::*;
#(
   parameter int DEPTH           = DMA_DEPTH,
   parameter int NEARLY_EMPTY_TH = DMA_NEARLY_EMPTY_TH,
   parameter int NEARLY_FULL_TH  = DMA_NEARLY_FULL_TH
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic [3:0]  dma_pkt_avail_o,
   input  logic [3:0]  dma_request_i,
   output logic [31:0] dma_data_o,
   input  logic        dma_rd_en_i,
   output logic [3:0]  dma_tx_full_o,
   output logic        dma_nearly_empty_o,
   output logic        dma_empty_o,
   output logic        dma_all_in_buf_o,
   input  logic [3:0]  cpci_dma_pkt_avail_i,
   output logic [3:0]  cpci_dma_send_o,
   output logic        cpci_dma_nearly_full_o,
   input  logic        cpci_dma_wr_en_i,
   input  logic [31:0] cpci_dma_data_i,
   input  logic [3:0]  cpci_tx_full_i,
   output pkt_state_e  pkt_state_o
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic [3:0]           pkt_avail_q, tx_full_q;
   logic [3:0]           send_q, send_d;
   pkt_state_e           state_q, state_d;
   logic [DMA_REM_W-1:0] remaining_q, remaining_d;
   logic [DMA_REM_W-1:0] hdr_len_words;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     free_words;
   logic                 wr_accept;

   cnet_dma_sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .wr_en_i     (cpci_dma_wr_en_i),
      .wr_data_i   (cpci_dma_data_i),
      .rd_en_i     (dma_rd_en_i),
      .rd_data_o   (dma_data_o),
      .count_o     (count),
      .wr_accept_o (wr_accept)
   );

   // Any write cycle clears pending requests, even one arriving the same cycle.
   assign send_d = cpci_dma_wr_en_i ? 4'b0000 : (send_q | dma_request_i);

   assign hdr_len_words = hdr_words(cpci_dma_data_i[15:0]);

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      if (wr_accept) begin
         unique case (state_q)
            ST_BODY: begin
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == DMA_REM_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
            default: begin
               remaining_d = hdr_len_words;
               state_d     = (hdr_len_words != '0) ? ST_BODY : ST_DONE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pkt_avail_q <= '0;
         tx_full_q   <= '0;
         send_q      <= '0;
         state_q     <= ST_HDR;
         remaining_q <= '0;
      end else begin
         pkt_avail_q <= cpci_dma_pkt_avail_i;
         tx_full_q   <= cpci_tx_full_i;
         send_q      <= send_d;
         state_q     <= state_d;
         remaining_q <= remaining_d;
      end
   end

   assign free_words = CNT_W'(DEPTH) - count;

   assign dma_pkt_avail_o        = pkt_avail_q;
   assign dma_tx_full_o          = tx_full_q;
   assign cpci_dma_send_o        = send_q;
   assign dma_empty_o            = (count == '0);
   assign dma_nearly_empty_o     = (count <= CNT_W'(NEARLY_EMPTY_TH));
   assign cpci_dma_nearly_full_o = (free_words <= CNT_W'(NEARLY_FULL_TH));
   assign dma_all_in_buf_o       = (state_q == ST_DONE);
   assign pkt_state_o            = state_q;

endmodule

// File: tb/tb_cnet_dma_buffer.sv
// Directed bench for cnet_dma_buffer: status pass-through, request latch,
// a full 2040-byte packet, overflow/underflow and zero-length headers.
module tb_cnet_dma_buffer;
   import cnet_dma_buffer_pkg::*;

   logic        clk;
   logic        reset;
   logic [3:0]  dma_pkt_avail;
   logic [3:0]  dma_request;
   logic [31:0] dma_data;
   logic        dma_rd_en;
   logic [3:0]  dma_tx_full;
   logic        dma_nearly_empty;
   logic        dma_empty;
   logic        dma_all_in_buf;
   logic [3:0]  cpci_dma_pkt_avail;
   logic [3:0]  cpci_dma_send;
   logic        cpci_dma_nearly_full;
   logic        cpci_dma_wr_en;
   logic [31:0] cpci_dma_data;
   logic [3:0]  cpci_tx_full;
   pkt_state_e  pkt_state;

   int n_cmp = 0;
   int n_bad = 0;
   int cnt;

   cnet_dma_buffer dut (
      .clk_i                  (clk),
      .reset_i                (reset),
      .dma_pkt_avail_o        (dma_pkt_avail),
      .dma_request_i          (dma_request),
      .dma_data_o             (dma_data),
      .dma_rd_en_i            (dma_rd_en),
      .dma_tx_full_o          (dma_tx_full),
      .dma_nearly_empty_o     (dma_nearly_empty),
      .dma_empty_o            (dma_empty),
      .dma_all_in_buf_o       (dma_all_in_buf),
      .cpci_dma_pkt_avail_i   (cpci_dma_pkt_avail),
      .cpci_dma_send_o        (cpci_dma_send),
      .cpci_dma_nearly_full_o (cpci_dma_nearly_full),
      .cpci_dma_wr_en_i       (cpci_dma_wr_en),
      .cpci_dma_data_i        (cpci_dma_data),
      .cpci_tx_full_i         (cpci_tx_full),
      .pkt_state_o            (pkt_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic write_word(input logic [31:0] d);
      cpci_dma_wr_en = 1'b1;
      cpci_dma_data  = d;
      tick();
      cpci_dma_wr_en = 1'b0;
   endtask

   task automatic read_word();
      dma_rd_en = 1'b1;
      tick();
      dma_rd_en = 1'b0;
   endtask

   initial begin
      reset              = 1'b1;
      dma_request        = '0;
      dma_rd_en          = 1'b0;
      cpci_dma_pkt_avail = '0;
      cpci_dma_wr_en     = 1'b0;
      cpci_dma_data      = '0;
      cpci_tx_full       = '0;
      tick();
      tick();
      reset = 1'b0;

      check_val("rst_empty", 32'(dma_empty), 32'd1);
      check_val("rst_nempty", 32'(dma_nearly_empty), 32'd1);
      check_val("rst_allin", 32'(dma_all_in_buf), 32'd0);
      check_val("rst_nfull", 32'(cpci_dma_nearly_full), 32'd0);
      check_val("rst_send", 32'(cpci_dma_send), 32'd0);
      check_val("rst_data", dma_data, 32'd0);
      check_val("rst_avail", 32'(dma_pkt_avail), 32'd0);
      check_val("rst_txfull", 32'(dma_tx_full), 32'd0);
      check_val("rst_state", 32'(pkt_state), 32'(ST_HDR));

      for (int i = 0; i < 16; i++) begin
         cpci_dma_pkt_avail = 4'(i);
         cpci_tx_full       = 4'(15 - i);
         tick();
         check_val("avail", 32'(dma_pkt_avail), 32'(i));
         check_val("txfull", 32'(dma_tx_full), 32'(15 - i));
      end

      for (int v = 0; v < 16; v++) begin
         do_reset();
         check_val("req_rst0", 32'(cpci_dma_send), 32'd0);
         dma_request = 4'(v);
         tick();
         dma_request = '0;
         check_val("req_latch", 32'(cpci_dma_send), 32'(v));
         tick();
         check_val("req_hold", 32'(cpci_dma_send), 32'(v));
      end
      do_reset();
      check_val("req_clear", 32'(cpci_dma_send), 32'd0);

      // Request then a 2040-byte packet: header plus 510 body words.
      dma_request = 4'b0001;
      tick();
      dma_request = '0;
      check_val("send_1", 32'(cpci_dma_send), 32'd1);
      write_word(32'd2040);
      check_val("send_clr", 32'(cpci_dma_send), 32'd0);
      check_val("hdr_empty", 32'(dma_empty), 32'd0);
      check_val("hdr_nempty", 32'(dma_nearly_empty), 32'd1);
      check_val("hdr_allin", 32'(dma_all_in_buf), 32'd0);
      for (int i = 0; i < 510; i++) begin
         write_word(32'(i));
         if (i == 508) check_val("body_allin_early", 32'(dma_all_in_buf), 32'd0);
      end
      check_val("pkt_nfull", 32'(cpci_dma_nearly_full), 32'd1);
      check_val("pkt_nempty", 32'(dma_nearly_empty), 32'd0);
      check_val("pkt_allin", 32'(dma_all_in_buf), 32'd1);

      cnt = 511;
      read_word();
      cnt--;
      check_val("rd_hdr", dma_data, 32'd2040);
      for (int i = 0; i < 510; i++) begin
         read_word();
         cnt--;
         check_val("rd_body", dma_data, 32'(i));
         check_val("rd_nempty", 32'(dma_nearly_empty), 32'(cnt <= 4));
      end
      check_val("drain_nempty", 32'(dma_nearly_empty), 32'd1);
      check_val("drain_empty", 32'(dma_empty), 32'd1);
      check_val("drain_allin", 32'(dma_all_in_buf), 32'd1);

      // Fill completely, then attempt one extra write that must be dropped.
      do_reset();
      for (int j = 0; j < 512; j++) write_word(32'hA000_0000 + 32'(j));
      check_val("full_empty", 32'(dma_empty), 32'd0);
      check_val("full_nfull", 32'(cpci_dma_nearly_full), 32'd1);
      write_word(32'hDEAD_BEEF);
      for (int j = 0; j < 512; j++) begin
         read_word();
         check_val("full_rd", dma_data, 32'hA000_0000 + 32'(j));
         if (j == 510) check_val("full_not_empty", 32'(dma_empty), 32'd0);
      end
      check_val("full_drained", 32'(dma_empty), 32'd1);
      read_word();
      check_val("uflow_data", dma_data, 32'hA000_01FF);
      check_val("uflow_empty", 32'(dma_empty), 32'd1);

      // Zero-length header, a one-word packet, then a simultaneous read/write.
      do_reset();
      check_val("z_allin_rst", 32'(dma_all_in_buf), 32'd0);
      write_word(32'd0);
      check_val("z_allin", 32'(dma_all_in_buf), 32'd1);
      write_word(32'd3);
      check_val("h3_allin", 32'(dma_all_in_buf), 32'd0);
      check_val("h3_state", 32'(pkt_state), 32'(ST_BODY));
      write_word(32'h55);
      check_val("b1_allin", 32'(dma_all_in_buf), 32'd1);
      cpci_dma_wr_en = 1'b1;
      cpci_dma_data  = 32'h66;
      dma_rd_en      = 1'b1;
      tick();
      cpci_dma_wr_en = 1'b0;
      dma_rd_en      = 1'b0;
      check_val("rw_data", dma_data, 32'd0);
      check_val("rw_allin", 32'(dma_all_in_buf), 32'd0);
      read_word();
      check_val("rw_rd1", dma_data, 32'd3);
      read_word();
      check_val("rw_rd2", dma_data, 32'h55);
      check_val("rw_not_empty", 32'(dma_empty), 32'd0);
      read_word();
      check_val("rw_rd3", dma_data, 32'h66);
      check_val("rw_empty", 32'(dma_empty), 32'd1);

      // Reset in the middle of a packet with a request pending.
      write_word(32'd8);
      write_word(32'h1234);
      dma_request = 4'b0010;
      tick();
      dma_request = '0;
      check_val("mid_send", 32'(cpci_dma_send), 32'd2);
      do_reset();
      check_val("mid_empty", 32'(dma_empty), 32'd1);
      check_val("mid_send_clr", 32'(cpci_dma_send), 32'd0);
      check_val("mid_allin", 32'(dma_all_in_buf), 32'd0);
      check_val("mid_state", 32'(pkt_state), 32'(ST_HDR));
      check_val("mid_data", dma_data, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
